// File: rtl/mips_multicycle_control.sv
// -----------------------------------------------------------------------------
// mips_multicycle_control
//
// Multicycle control FSM for the MIPS datapath. Each instruction walks through
// FETCH -> DECODE -> class-specific states and ends in a single state that
// asserts pcWrite. All mux encodings match the datapath port-for-port.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   undefined (default): an unsupported opcode/funct retires as a NOP.
//   defined            : it traps into HALT (halted=1) until rst.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-high reset
//   opcode       in   6      instruction[31:26], sampled in DECODE
//   funct        in   6      instruction[5:0], sampled in DECODE
//   zero         in   1      ALU zero flag, used in BRANCH
//   pcSrc        out  2      0=pc+4 1=branch 2=jump 3=rs (jr)
//   regDst       out  2      0=rt 1=rd 2=r31
//   regSrc       out  2      0=pc (link) 1=memory 2=ALU
//   ALUSrc       out  1      0=register 1=sign-extended immediate
//   ALUOp        out  2      00=add 01=sub 10=by funct 11=slt
//   regWrite     out  1      register-file write enable
//   memWrite     out  1      data-memory write enable
//   memRead      out  1      data-memory read strobe
//   irWrite      out  1      instruction-register load
//   pcWrite      out  1      PC update, once per retired instruction
//   illegal      out  1      pulse in DECODE on unsupported instruction
//   halted       out  1      trap halt flag (0 unless ILLEGAL_TRAP_EN)
//   instr_count  out  CNT_W  retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module mips_multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [1:0]       pcSrc,
  output logic [1:0]       regDst,
  output logic [1:0]       regSrc,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             regWrite,
  output logic             memWrite,
  output logic             memRead,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Mux encodings
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] SRC_PC  = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_ALU = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    WB_R,
    EXEC_I,
    WB_I,
    MEM_ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    BRANCH,
    JUMP
`ifdef ILLEGAL_TRAP_EN
    ,
    HALT
`endif
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_JR,
    C_ADDI,
    C_SLTI,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_J,
    C_JAL,
    C_ILL
  } iclass_t;

  function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn);
    iclass_t c;
    c = C_ILL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: c = C_RTYPE;
          FN_JR:                                 c = C_JR;
          default:                               c = C_ILL;
        endcase
      end
      OP_ADDI: c = C_ADDI;
      OP_SLTI: c = C_SLTI;
      OP_LW:   c = C_LW;
      OP_SW:   c = C_SW;
      OP_BEQ:  c = C_BEQ;
      OP_BNE:  c = C_BNE;
      OP_J:    c = C_J;
      OP_JAL:  c = C_JAL;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [5:0]       opcode_q, funct_q;
  logic [CNT_W-1:0] count_q;

  // DECODE steers on the live instruction bits; later states use the copy
  // latched on the edge that leaves DECODE.
  iclass_t dec_class, cur_class;
  assign dec_class = classify(opcode, funct);
  assign cur_class = classify(opcode_q, funct_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      funct_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
      if (pcWrite) count_q <= count_q + CNT_W'(1);
    end
  end

  assign instr_count = count_q;

  // NOTE: every output and state_d gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pcSrc    = PC_PLUS4;
    regDst   = DST_RT;
    regSrc   = SRC_PC;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_ADD;
    regWrite = 1'b0;
    memWrite = 1'b0;
    memRead  = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        irWrite = 1'b1;
        memRead = 1'b1;
        state_d = DECODE;
      end

      DECODE: begin
        case (dec_class)
          C_RTYPE:              state_d = EXEC_R;
          C_JR, C_J, C_JAL:     state_d = JUMP;
          C_ADDI, C_SLTI:       state_d = EXEC_I;
          C_LW, C_SW:           state_d = MEM_ADDR;
          C_BEQ, C_BNE:         state_d = BRANCH;
          default: begin
            illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            state_d = HALT;
`else
            // Retire as a NOP: advance PC by 4 straight from DECODE.
            pcWrite = 1'b1;
            state_d = FETCH;
`endif
          end
        endcase
      end

      EXEC_R: begin
        ALUOp   = ALU_FUNCT;
        state_d = WB_R;
      end

      WB_R: begin
        ALUOp    = ALU_FUNCT;
        regDst   = DST_RD;
        regSrc   = SRC_ALU;
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        state_d  = FETCH;
      end

      EXEC_I: begin
        ALUSrc  = 1'b1;
        ALUOp   = (cur_class == C_SLTI) ? ALU_SLT : ALU_ADD;
        state_d = WB_I;
      end

      WB_I: begin
        ALUSrc   = 1'b1;
        ALUOp    = (cur_class == C_SLTI) ? ALU_SLT : ALU_ADD;
        regDst   = DST_RT;
        regSrc   = SRC_ALU;
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        state_d  = FETCH;
      end

      MEM_ADDR: begin
        ALUSrc  = 1'b1;
        state_d = (cur_class == C_SW) ? MEM_WR : MEM_RD;
      end

      MEM_RD: begin
        ALUSrc  = 1'b1;
        memRead = 1'b1;
        state_d = WB_MEM;
      end

      WB_MEM: begin
        ALUSrc   = 1'b1;
        regDst   = DST_RT;
        regSrc   = SRC_MEM;
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        state_d  = FETCH;
      end

      MEM_WR: begin
        ALUSrc   = 1'b1;
        memWrite = 1'b1;
        pcWrite  = 1'b1;
        state_d  = FETCH;
      end

      BRANCH: begin
        ALUOp   = ALU_SUB;
        pcWrite = 1'b1;
        // beq takes on equal (zero=1), bne on not-equal (zero=0).
        if ((cur_class == C_BEQ && zero) || (cur_class == C_BNE && !zero))
          pcSrc = PC_BRANCH;
        state_d = FETCH;
      end

      JUMP: begin
        pcWrite = 1'b1;
        case (cur_class)
          C_JR:  pcSrc = PC_RS;
          C_JAL: begin
            pcSrc    = PC_JUMP;
            regDst   = DST_R31;
            regSrc   = SRC_PC;
            regWrite = 1'b1;
          end
          default: pcSrc = PC_JUMP;
        endcase
        state_d = FETCH;
      end

`ifdef ILLEGAL_TRAP_EN
      HALT: begin
        halted  = 1'b1;
        state_d = HALT;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             zero = 1'b0;
  logic [1:0]       pcSrc, regDst, regSrc, ALUOp;
  logic             ALUSrc, regWrite, memWrite, memRead, irWrite, pcWrite;
  logic             illegal, halted;
  logic [CNT_W-1:0] instr_count;

  mips_multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pcSrc      (pcSrc),
    .regDst     (regDst),
    .regSrc     (regSrc),
    .ALUSrc     (ALUSrc),
    .ALUOp      (ALUOp),
    .regWrite   (regWrite),
    .memWrite   (memWrite),
    .memRead    (memRead),
    .irWrite    (irWrite),
    .pcWrite    (pcWrite),
    .illegal    (illegal),
    .halted     (halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Expected outputs of the retiring (pcWrite) cycle of one instruction.
  typedef struct {
    int               lat;
    logic [1:0]       pc_src;
    logic [1:0]       reg_dst;
    logic [1:0]       reg_src;
    logic [1:0]       alu_op;
    logic             alu_src;
    logic             reg_write;
    logic             mem_write;
    logic             ill;
    logic [CNT_W-1:0] count;
  } exp_t;

  exp_t             sb_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_count = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: counts cycles since FETCH and scores every retiring cycle.
  int cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cyc = 0;
    end else begin
      if (irWrite) cyc = 1;
      else         cyc = cyc + 1;
      if (pcWrite) begin
        if (sb_q.size() == 0) begin
          check("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("latency",     cyc,         e.lat);
          check("pcSrc",       pcSrc,       e.pc_src);
          check("regDst",      regDst,      e.reg_dst);
          check("regSrc",      regSrc,      e.reg_src);
          check("ALUOp",       ALUOp,       e.alu_op);
          check("ALUSrc",      ALUSrc,      e.alu_src);
          check("regWrite",    regWrite,    e.reg_write);
          check("memWrite",    memWrite,    e.mem_write);
          check("illegal",     illegal,     e.ill);
          check("memRead",     memRead,     1'b0);
          check("instr_count", instr_count, e.count);
        end
      end
    end
  end

  // Driver: waits for FETCH, presents the instruction, queues its expectation.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int lat, input logic [1:0] pc_src, input logic [1:0] reg_dst,
                          input logic [1:0] reg_src, input logic [1:0] alu_op,
                          input logic alu_src, input logic rw, input logic mw, input logic ill);
    exp_t e;
    int   n;
    n = 0;
    while (!irWrite && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!irWrite) begin
      check("fetch_timeout", 32'd0, 32'd1);
      return;
    end
    opcode = op;
    funct  = fn;
    zero   = z;
    e.lat       = lat;
    e.pc_src    = pc_src;
    e.reg_dst   = reg_dst;
    e.reg_src   = reg_src;
    e.alu_op    = alu_op;
    e.alu_src   = alu_src;
    e.reg_write = rw;
    e.mem_write = mw;
    e.ill       = ill;
    e.count     = exp_count;
    sb_q.push_back(e);
    exp_count = exp_count + 1'b1;
    @(negedge clk);
  endtask

  task automatic r_type(input logic [5:0] fn);
    do_instr(6'h00, fn, 1'b0, 4, 2'd0, 2'd1, 2'd2, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic branch(input logic [5:0] op, input logic z, input logic [1:0] pc_src);
    do_instr(op, 6'h00, z, 3, pc_src, 2'd0, 2'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic jump_j();
    do_instr(6'h02, 6'h00, 1'b0, 3, 2'd2, 2'd0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;

    // Reset and the IDLE cycle after release
    repeat (2) @(negedge clk);
    check("reset_outputs", {pcSrc, regDst, regSrc, ALUOp, ALUSrc, regWrite, memWrite,
                            memRead, irWrite, pcWrite, illegal, halted}, 32'd0);
    check("reset_count", instr_count, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_outputs", {pcSrc, regDst, regSrc, ALUOp, ALUSrc, regWrite, memWrite,
                           memRead, irWrite, pcWrite, illegal, halted}, 32'd0);
    @(negedge clk);
    check("fetch_irWrite", irWrite, 1'b1);
    check("fetch_memRead", memRead, 1'b1);

    //       op     fn     z     lat pcSrc dst   src   aluop  alusrc rw    mw    ill
    r_type(6'h20);                                                          // add
    do_instr(6'h23, 6'h00, 1'b0, 5, 2'd0, 2'd0, 2'd1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0); // lw
    do_instr(6'h2B, 6'h00, 1'b0, 4, 2'd0, 2'd0, 2'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0); // sw
    branch(6'h04, 1'b1, 2'd1);                                              // beq taken
    branch(6'h04, 1'b0, 2'd0);                                              // beq not taken
    branch(6'h05, 1'b0, 2'd1);                                              // bne taken
    branch(6'h05, 1'b1, 2'd0);                                              // bne not taken
    do_instr(6'h03, 6'h00, 1'b0, 3, 2'd2, 2'd2, 2'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); // jal
    do_instr(6'h00, 6'h08, 1'b0, 3, 2'd3, 2'd0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); // jr
    jump_j();                                                               // j
    do_instr(6'h08, 6'h00, 1'b0, 4, 2'd0, 2'd0, 2'd2, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0); // addi
    do_instr(6'h0A, 6'h00, 1'b0, 4, 2'd0, 2'd0, 2'd2, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0); // slti
    r_type(6'h22);                                                          // sub
    r_type(6'h24);                                                          // and
    r_type(6'h25);                                                          // or
    r_type(6'h2A);                                                          // slt
`ifndef ILLEGAL_TRAP_EN
    do_instr(6'h3F, 6'h00, 1'b0, 2, 2'd0, 2'd0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1); // bad opcode
    do_instr(6'h00, 6'h3F, 1'b0, 2, 2'd0, 2'd0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1); // bad funct
`endif

    // Reset in the middle of a store: strobes drop at once, count clears.
    do_instr(6'h2B, 6'h00, 1'b0, 4, 2'd0, 2'd0, 2'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!memWrite && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reach_mem_wr", memWrite, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midreset_memWrite", memWrite, 1'b0);
    check("midreset_pcWrite",  pcWrite,  1'b0);
    check("midreset_count",    instr_count, 32'd0);
    exp_count = '0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Bring the counter up to its maximum with jumps.
    while (exp_count != CNT_MAX) jump_j();
    wait_drained();

`ifdef ILLEGAL_TRAP_EN
    // Trap: illegal in DECODE, no pcWrite, then HALT forever.
    n = 0;
    while (!irWrite && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("trap_fetch", irWrite, 1'b1);
    opcode = 6'h3F;
    funct  = 6'h00;
    @(negedge clk);
    check("trap_illegal", illegal, 1'b1);
    check("trap_no_pcWrite", pcWrite, 1'b0);
    @(negedge clk);
    check("trap_halted", halted, 1'b1);
    check("trap_strobes", {irWrite, memRead, pcWrite, regWrite, memWrite}, 32'd0);
    repeat (5) @(negedge clk);
    check("trap_halted_held", halted, 1'b1);
    check("trap_count_frozen", instr_count, CNT_MAX);
`else
    // NOP retiring from the maximum count wraps the counter to 0.
    do_instr(6'h3F, 6'h00, 1'b0, 2, 2'd0, 2'd0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drained();
    @(posedge clk);
    #1;
    check("wrap_count", instr_count, 32'd0);
`endif

    rst = 1'b1;
    #1;
    check("queue_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
